// File: rtl/micro_pkg.sv
// Shared constants for the microprogrammed MIPS control path:
// micro-state numbers, AddrCtrl encodings and supported opcodes.
package micro_pkg;

    localparam int unsigned ST_W = 4;
    localparam int unsigned OP_W = 6;
    localparam int unsigned AC_W = 2;

    localparam logic [ST_W-1:0] S_FETCH  = 4'd0;
    localparam logic [ST_W-1:0] S_DECODE = 4'd1;
    localparam logic [ST_W-1:0] S_MEMADR = 4'd2;
    localparam logic [ST_W-1:0] S_MEMRD  = 4'd3;
    localparam logic [ST_W-1:0] S_MEMWB  = 4'd4;
    localparam logic [ST_W-1:0] S_MEMWR  = 4'd5;
    localparam logic [ST_W-1:0] S_REXEC  = 4'd6;
    localparam logic [ST_W-1:0] S_RWB    = 4'd7;
    localparam logic [ST_W-1:0] S_BEQ    = 4'd8;
    localparam logic [ST_W-1:0] S_JUMP   = 4'd9;
    localparam logic [ST_W-1:0] S_BNE    = 4'd10;
    localparam logic [ST_W-1:0] S_ADDIEX = 4'd11;
    localparam logic [ST_W-1:0] S_ADDIWB = 4'd12;

    localparam logic [AC_W-1:0] AC_FETCH = 2'b00;
    localparam logic [AC_W-1:0] AC_DISP1 = 2'b01;
    localparam logic [AC_W-1:0] AC_DISP2 = 2'b10;
    localparam logic [AC_W-1:0] AC_SEQ   = 2'b11;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

endpackage

// File: rtl/dispatch_rom.sv
// Opcode dispatch tables: DECODE target (table 1) and MEMADR target (table 2).
// Purely combinational; a miss is reported through the *_hit flags.
module dispatch_rom
    import micro_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output logic [ST_W-1:0] d1_addr,
    output logic            d1_hit,
    output logic [ST_W-1:0] d2_addr,
    output logic            d2_hit
);

    always_comb begin
        d1_addr = S_FETCH;
        d1_hit  = 1'b1;
        unique case (opcode)
            OP_RTYPE:    d1_addr = S_REXEC;
            OP_LW, OP_SW: d1_addr = S_MEMADR;
            OP_BEQ:      d1_addr = S_BEQ;
            OP_BNE:      d1_addr = S_BNE;
            OP_J:        d1_addr = S_JUMP;
            OP_ADDI:     d1_addr = S_ADDIEX;
            default:     d1_hit  = 1'b0;
        endcase
    end

    always_comb begin
        d2_addr = S_FETCH;
        d2_hit  = 1'b1;
        unique case (opcode)
            OP_LW:   d2_addr = S_MEMRD;
            OP_SW:   d2_addr = S_MEMWR;
            default: d2_hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address sequencer for the microcode ROM: holds the uPC, picks the next
// state from AddrCtrl/opcode, flags illegal opcodes and counts retired instructions.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int unsigned UPC_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [OP_W-1:0]  opcode,
    input  logic [AC_W-1:0]  addr_ctrl,
    output logic [UPC_W-1:0] upc,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    logic [ST_W-1:0]  d1_addr;
    logic [ST_W-1:0]  d2_addr;
    logic             d1_hit;
    logic             d2_hit;
    logic [UPC_W-1:0] upc_nxt;
    logic             done_nxt;
    logic             ill_nxt;

    dispatch_rom u_dispatch_rom (
        .opcode  (opcode),
        .d1_addr (d1_addr),
        .d1_hit  (d1_hit),
        .d2_addr (d2_addr),
        .d2_hit  (d2_hit)
    );

    // Next-state select; states above ADDIWB are unreachable and recover to FETCH.
    always_comb begin
        upc_nxt  = upc;
        done_nxt = 1'b0;
        ill_nxt  = 1'b0;
        if (en) begin
            if (upc > UPC_W'(S_ADDIWB)) begin
                upc_nxt = UPC_W'(S_FETCH);
                ill_nxt = 1'b1;
            end else begin
                unique case (addr_ctrl)
                    AC_FETCH: begin
                        upc_nxt  = UPC_W'(S_FETCH);
                        done_nxt = (upc != UPC_W'(S_FETCH));
                    end
                    AC_DISP1: begin
                        upc_nxt = d1_hit ? UPC_W'(d1_addr) : UPC_W'(S_FETCH);
                        ill_nxt = ~d1_hit;
                    end
                    AC_DISP2: begin
                        upc_nxt = d2_hit ? UPC_W'(d2_addr) : UPC_W'(S_FETCH);
                        ill_nxt = ~d2_hit;
                    end
                    default: upc_nxt = upc + UPC_W'(1);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc        <= '0;
            instr_done <= 1'b0;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            upc        <= upc_nxt;
            instr_done <= done_nxt;
            illegal_op <= ill_nxt;
            if (done_nxt) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-address sequencer for the multicycle MIPS microprogrammed control unit. Holds the micro-program counter (uPC), which addresses the microcode ROM in `microprogram`. Each cycle it selects the next uPC from the ROM's 2-bit `AddrCtrl` field and the current instruction `opcode`, using fetch-reset, two dispatch tables, or sequential increment. It also reports illegal opcodes and counts retired instructions.

## Interface
- `UPC_W`, default 4: uPC width; must be ≥ 4 to hold states 0–12.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  step enable; when 0, all state holds.
- `opcode`  in  6  IR[31:26]; valid from state 1 onward.
- `addr_ctrl`  in  2  `AddrCtrl` from the microcode ROM for the current uPC.
- `upc`  out  UPC_W  current micro-state; drives the microcode ROM address.
- `instr_done`  out  1  one-cycle pulse when a normal instruction completes.
- `illegal_op`  out  1  one-cycle pulse when a dispatch sees an unsupported opcode.
- `retired`  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

## Operation
- Micro-states:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR
  - 6 REXEC, 7 RWB, 8 BEQ, 9 JUMP, 10 BNE, 11 ADDIEX, 12 ADDIWB
  - 13–15 unused.
- `addr_ctrl` encoding:
  - 00 FETCH: next = 0.
  - 01 DISP1: next = dispatch-1 entry for `opcode`.
  - 10 DISP2: next = dispatch-2 entry for `opcode`.
  - 11 SEQ: next = upc+1.
- Dispatch 1:
  - 000000 (R-type) → 6
  - 100011 (lw) → 2
  - 101011 (sw) → 2
  - 000100 (beq) → 8
  - 000101 (bne) → 10
  - 000010 (j) → 9
  - 001000 (addi) → 11
- Dispatch 2: lw → 3, sw → 5.
- Miss in either dispatch table: next = 0, and `illegal_op` pulses.
- `instr_done`: registered pulse, asserted the cycle after a transition to 0 made with `addr_ctrl`=FETCH from any uPC ≠ 0. `retired` increments at that same edge.
- FETCH from an illegal dispatch does not count: that transition uses DISP1/DISP2, not FETCH.
- SEQ increment is modulo 2^UPC_W. If uPC is in an unused state (13–15), next = 0 regardless of `addr_ctrl`. That transition:
  - does not assert `instr_done`;
  - asserts `illegal_op`.
- `en`=0:
  - uPC and `retired` hold.
  - `instr_done` and `illegal_op` are driven 0.

## Timing
- Reset (async assert, sync release) sets `upc`=0, `retired`=0, `instr_done`=0, `illegal_op`=0.
- Reset asserted mid-instruction abandons that instruction; it is not counted.
- `upc` is a register. The next-state logic is combinational from `upc`, `addr_ctrl`, `opcode`, `en`. `addr_ctrl` is combinational from `upc` through the ROM, with no loop through `upc`'s register.
- Latency: a one-cycle micro-step per enabled clock. Instruction lengths in cycles:
  - lw 5; sw 4; R-type 4; addi 4
  - beq 3; bne 3; j 3
- `opcode` must be stable in any cycle where `addr_ctrl` ∈ {DISP1, DISP2}. `opcode` is ignored otherwise.
- `instr_done` and `illegal_op` are registered, and are never asserted in the same cycle.
- Counter wrap: all-ones + 1 → 0, with no flag.

## Structure
- Package `micro_pkg`:
  - uPC state constants (S_FETCH…S_ADDIWB)
  - `addr_ctrl` encodings (AC_FETCH, AC_DISP1, AC_DISP2, AC_SEQ)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI)
- Sub-module `dispatch_rom`:
  - Purely combinational.
  - Input: `opcode`. Outputs: `d1_addr`, `d1_hit`, `d2_addr`, `d2_hit`.
  - Shared later with the hardwired-control variant.
- The sequencer instantiates `dispatch_rom` and contains the uPC register, the next-state mux, the pulse registers and the counter.

## Test plan
- **Reset:** `rst_n`=0 mid-state 3 → `upc`=0 immediately, `retired`=0. After release, FETCH (ac=11) → `upc`=1 on the next edge.
- **lw:** drive the ac sequence 11,01,10,11,00 with opcode 100011 → `upc` path 0,1,2,3,4,0. `instr_done` pulses once; `retired` increments 0 → 1.
- **Dispatch coverage:**
  - R-type → 6,7,0
  - sw → 2,5,0
  - beq → 8,0
  - bne → 10,0
  - j → 9,0
  - addi → 11,12,0
  - Expected at end: `retired`=6.
- **Illegal opcode:** opcode 111111 at DISP1 from `upc`=1 → next `upc`=0, `illegal_op`=1 for one cycle, `instr_done`=0, `retired` unchanged. Likewise opcode 000000 at DISP2 from `upc`=2.
- **Stall:** `en`=0 for 3 cycles in state 6 → `upc` stays 6 with both pulses 0. With `en`=1, the path resumes 7,0.
- **Counter wrap and unused state:**
  - CNT_W=4: 16 completed jumps → `retired` wraps from 15 to 0.
  - Force `upc`=13 via a hierarchical deposit → next `upc`=0 and `illegal_op` pulses.
